// File: rtl/note_hit_judge_if.sv
// Signal bundle between the note stream / pitch detector side and the hit judge.
// Valid semantics: played_note is only meaningful while played_valid is high;
// hit and miss are single-cycle pulses.
interface note_hit_judge_if;
  logic [25:0] tempo_in;
  logic [3:0]  target_note;
  logic        song_done;
  logic [3:0]  played_note;
  logic        played_valid;
  logic        hit;
  logic        miss;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [7:0]  max_streak;
  logic [2:0]  multiplier;
  logic        judge_done;
  logic [2:0]  judge_state;

  modport master (
    output tempo_in, target_note, song_done, played_note, played_valid,
    input  hit, miss, score, streak, max_streak, multiplier, judge_done, judge_state
  );

  modport slave (
    input  tempo_in, target_note, song_done, played_note, played_valid,
    output hit, miss, score, streak, max_streak, multiplier, judge_done, judge_state
  );
endinterface

// File: rtl/note_hit_judge.sv
// Judges the played pitch against the hit-line note once per regenerated beat and
// keeps score, streak, best streak and multiplier; freezes at end of song.
module note_hit_judge #(
  parameter logic [15:0] HOLD_CYCLES = 16'd50000,
  parameter logic [7:0]  POINTS      = 8'd10,
  parameter logic [7:0]  MULT_STEP   = 8'd8,
  parameter logic [2:0]  MAX_MULT    = 3'd4
) (
  input  logic             clk,
  input  logic             reset,
  note_hit_judge_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_LISTEN = 3'd2,
    S_JUDGED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [25:0] beat_cnt;
  logic [25:0] period_m1;
  logic        beat;

  logic [3:0]  tgt, tgt_d;
  logic [15:0] hold_cnt, hold_d;
  logic [15:0] score, score_d;
  logic [7:0]  streak, streak_d;
  logic [7:0]  max_streak, max_d;
  logic [2:0]  multiplier, mult_d;
  logic        hit_c, miss_c;

  logic        match;
  logic [16:0] hold_inc;
  logic        hold_done;
  logic [10:0] award;
  logic [16:0] score_sum;
  logic [15:0] score_hit;
  logic [7:0]  streak_hit;
  logic [7:0]  max_hit;
  logic [8:0]  mult_raw;
  logic [2:0]  mult_hit;

  // A zero tempo behaves as a one-cycle period; >= lets a shrinking tempo end the period at once.
  assign period_m1 = (bus.tempo_in == 26'd0) ? 26'd0 : bus.tempo_in - 26'd1;
  assign beat      = (beat_cnt >= period_m1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= 26'd0;
    end else if (state != S_DONE) begin
      beat_cnt <= beat ? 26'd0 : beat_cnt + 26'd1;
    end
  end

  assign match     = bus.played_valid && (bus.played_note == tgt);
  assign hold_inc  = {1'b0, hold_cnt} + 17'd1;
  assign hold_done = match && (hold_inc >= {1'b0, HOLD_CYCLES});

  // Award uses the multiplier in force before this hit bumps the streak.
  assign award      = 11'(POINTS) * 11'(multiplier);
  assign score_sum  = {1'b0, score} + {6'd0, award};
  assign score_hit  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign streak_hit = (streak == 8'hFF) ? 8'hFF : streak + 8'd1;
  assign max_hit    = (streak_hit > max_streak) ? streak_hit : max_streak;
  assign mult_raw   = {1'b0, streak_hit / MULT_STEP} + 9'd1;
  assign mult_hit   = (mult_raw > {6'd0, MAX_MULT}) ? MAX_MULT : mult_raw[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tgt        <= 4'd0;
      hold_cnt   <= 16'd0;
      score      <= 16'd0;
      streak     <= 8'd0;
      max_streak <= 8'd0;
      multiplier <= 3'd1;
    end else begin
      state      <= state_d;
      tgt        <= tgt_d;
      hold_cnt   <= hold_d;
      score      <= score_d;
      streak     <= streak_d;
      max_streak <= max_d;
      multiplier <= mult_d;
    end
  end

  always_comb begin
    state_d  = state;
    tgt_d    = tgt;
    hold_d   = hold_cnt;
    score_d  = score;
    streak_d = streak;
    max_d    = max_streak;
    mult_d   = multiplier;
    hit_c    = 1'b0;
    miss_c   = 1'b0;
    if (bus.song_done) begin
      state_d = S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (beat) state_d = S_LATCH;
        end
        S_LATCH: begin
          if (bus.target_note == 4'hF) begin
            state_d = S_DONE;
          end else begin
            tgt_d   = bus.target_note;
            hold_d  = 16'd0;
            // Rests are never judged, so they skip straight to waiting for the next beat.
            state_d = (bus.target_note == 4'd0) ? S_JUDGED : S_LISTEN;
          end
        end
        S_LISTEN: begin
          hold_d = match ? hold_inc[15:0] : 16'd0;
          if (hold_done) begin
            hit_c    = 1'b1;
            score_d  = score_hit;
            streak_d = streak_hit;
            max_d    = max_hit;
            mult_d   = mult_hit;
            state_d  = beat ? S_LATCH : S_JUDGED;
          end else if (beat) begin
            miss_c   = 1'b1;
            streak_d = 8'd0;
            mult_d   = 3'd1;
            state_d  = S_LATCH;
          end
        end
        S_JUDGED: begin
          if (beat) state_d = S_LATCH;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.hit         = hit_c;
  assign bus.miss        = miss_c;
  assign bus.score       = score;
  assign bus.streak      = streak;
  assign bus.max_streak  = max_streak;
  assign bus.multiplier  = multiplier;
  assign bus.judge_done  = (state == S_DONE);
  assign bus.judge_state = state;

endmodule

// File: tb/tb_note_hit_judge.sv
// Directed bench for note_hit_judge: beat-aligned windows of stimulus, expected
// hit/miss results queued at issue time and matched by an independent monitor.
module tb_note_hit_judge;
  localparam int T = 20;
  localparam int W = 42;
  localparam logic [1:0] K_HIT  = 2'b10;
  localparam logic [1:0] K_MISS = 2'b01;
  localparam logic [19:0] FULL  = 20'hFFFFE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];
  int   m_score, m_streak, m_max, m_mult;

  note_hit_judge_if bus();

  note_hit_judge #(
    .HOLD_CYCLES(16'd4),
    .POINTS(8'd10),
    .MULT_STEP(8'd8),
    .MAX_MULT(3'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_streak = 0; m_max = 0; m_mult = 1;
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [1:0] kind, input int off);
    if (kind == K_HIT) begin
      m_score = m_score + 10 * m_mult;
      if (m_score > 65535) m_score = 65535;
      if (m_streak < 255) m_streak = m_streak + 1;
      if (m_streak > m_max) m_max = m_streak;
      m_mult = 1 + m_streak / 8;
      if (m_mult > 4) m_mult = 4;
    end else begin
      m_streak = 0;
      m_mult = 1;
    end
    exp_q.push_back({kind, 5'(off), 16'(m_score), 8'(m_streak), 8'(m_max), 3'(m_mult)});
  endtask

  // Drives one beat window, starting in the LATCH cycle (offset 0) and ending after the beat (offset 19).
  task automatic window(input logic [3:0] tgt, input logic [3:0] note, input logic [19:0] mask,
                        input int done_off);
    for (int off = 0; off < T; off++) begin
      bus.target_note  = tgt;
      bus.played_note  = note;
      bus.played_valid = mask[off];
      bus.song_done    = (done_off >= 0) && (off >= done_off);
      @(posedge clk); #1;
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
    repeat (T) @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk); #2;
    reset = 1'b1;
    bus.song_done = 1'b0; bus.played_valid = 1'b0; bus.target_note = 4'd0;
    #1;
    check({tag, "_score"}, bus.score, 0);
    check({tag, "_streak"}, bus.streak, 0);
    check({tag, "_max"}, bus.max_streak, 0);
    check({tag, "_mult"}, bus.multiplier, 1);
    check({tag, "_done"}, bus.judge_done, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_pulse"}, {bus.hit, bus.miss}, 0);
    release_reset();
  endtask

  // monitor: pulse seen at one negedge, results compared at the next one
  initial begin
    logic pend;
    logic [1:0] pkind;
    logic [4:0] poff;
    logic [W-1:0] got, e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          got = {pkind, poff, bus.score, bus.streak, bus.max_streak, bus.multiplier};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse actual kind=%b off=%0d score=%0d streak=%0d required none",
                     pkind, poff, bus.score, bus.streak);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL pulse actual kind=%b off=%0d score=%0d streak=%0d max=%0d mult=%0d required kind=%b off=%0d score=%0d streak=%0d max=%0d mult=%0d",
                       got[41:40], got[39:35], got[34:19], got[18:11], got[10:3], got[2:0],
                       e[41:40], e[39:35], e[34:19], e[18:11], e[10:3], e[2:0]);
            end
          end
          pend = 1'b0;
        end
        if (bus.hit || bus.miss) begin
          pend  = 1'b1;
          pkind = {bus.hit, bus.miss};
          poff  = 5'(cyc % T);
        end
      end
    end
  end

  // stimulus
  initial begin
    bus.tempo_in = 26'd20;
    bus.target_note = 4'd0;
    bus.song_done = 1'b0;
    bus.played_note = 4'd0;
    bus.played_valid = 1'b0;
    model_reset();

    #12;
    check("rst_hit", bus.hit, 0);
    check("rst_miss", bus.miss, 0);
    check("rst_score", bus.score, 0);
    check("rst_streak", bus.streak, 0);
    check("rst_max", bus.max_streak, 0);
    check("rst_mult", bus.multiplier, 1);
    check("rst_done", bus.judge_done, 0);

    @(posedge clk); #1;
    release_reset();

    // T1: three clean hits
    for (int i = 0; i < 3; i++) begin
      push_exp(K_HIT, 4);
      window(4'd3, 4'd3, FULL, -1);
    end
    check("t1_score", bus.score, 30);
    check("t1_streak", bus.streak, 3);

    // T2: wrong pitch all window
    push_exp(K_MISS, 19);
    window(4'd5, 4'd6, FULL, -1);
    check("t2_score", bus.score, 30);
    check("t2_streak", bus.streak, 0);
    check("t2_mult", bus.multiplier, 1);

    // T3: rests
    window(4'd0, 4'd0, FULL, -1);
    window(4'd0, 4'd9, FULL, -1);
    check("t3_score", bus.score, 30);
    check("t3_streak", bus.streak, 0);

    // T4: multiplier ramp
    for (int i = 1; i <= 25; i++) begin
      push_exp(K_HIT, 4);
      window(4'd3, 4'd3, FULL, -1);
      if (i == 7) check("t4_mult7", bus.multiplier, 1);
      if (i == 8) begin
        check("t4_score8", bus.score, 110);
        check("t4_mult8", bus.multiplier, 2);
      end
      if (i == 9) check("t4_score9", bus.score, 130);
      if (i == 24) check("t4_mult24", bus.multiplier, 4);
    end
    check("t4_score25", bus.score, 550);
    check("t4_mult25", bus.multiplier, 4);
    check("t4_max25", bus.max_streak, 25);

    // T5a: hold completes on the beat, next window must be judged normally
    push_exp(K_HIT, 19);
    window(4'd7, 4'd7, 20'hF0000, -1);
    push_exp(K_HIT, 4);
    window(4'd7, 4'd7, FULL, -1);
    check("t5a_score", bus.score, 630);

    // T5b: valid drops one cycle short, hold restarts; then time runs out
    push_exp(K_HIT, 8);
    window(4'd7, 4'd7, 20'h001EE, -1);
    check("t5b_score", bus.score, 670);
    push_exp(K_MISS, 19);
    window(4'd7, 4'd7, 20'h7000E, -1);
    check("t5b_streak", bus.streak, 0);
    check("t5b_max", bus.max_streak, 28);

    // T6a: end marker freezes everything
    window(4'hF, 4'd3, FULL, -1);
    check("t6a_done", bus.judge_done, 1);
    check("t6a_score", bus.score, 670);
    window(4'd3, 4'd3, FULL, -1);
    check("t6a_done2", bus.judge_done, 1);
    check("t6a_score2", bus.score, 670);
    async_reset("t6a_rst");

    // T6b: song_done mid-listen, then reset during an active hold
    push_exp(K_HIT, 4);
    window(4'd3, 4'd3, FULL, -1);
    window(4'd3, 4'd3, FULL, 2);
    check("t6b_done", bus.judge_done, 1);
    check("t6b_score", bus.score, 10);
    check("t6b_streak", bus.streak, 1);
    async_reset("t6b_rst");
    bus.target_note = 4'd3; bus.played_note = 4'd3; bus.played_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    async_reset("t6c_rst");
    repeat (5) @(posedge clk);
    #1;
    check("t6c_score", bus.score, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
